// File: rtl/display_scheduler.sv
// display_scheduler: time-multiplexed 4-digit display driver.
// Adds per-slot blanking and per-digit blinking, and reloads digits only at frame boundaries so the display never tears.
module display_scheduler #(
  parameter int REFRESH_DIV  = 27000,
  parameter int BLANK_CYC    = 270,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [19:0] load_data,
  input  logic [3:0]  load_blink,
  output logic        load_ready,
  output logic [3:0]  anodo,
  output logic [4:0]  code,
  output logic        frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] C_SHOW = CW'(BLANK_CYC - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [0:0] BLANK = 1'b0;
  localparam logic [0:0] SHOW  = 1'b1;
  localparam logic [4:0] BLANK_CODE = 5'b10000;

  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_slot;
  logic [0:0]      r_state;
  logic [3:0][4:0] r_disp, r_pend_data;
  logic [3:0]      r_blink, r_pend_blink;
  logic            r_pend_full;
  logic [FW-1:0]   r_frame_cnt;
  logic            r_phase;
  logic            w_wrap, w_accept, w_sup;

  assign w_wrap     = r_cnt == C_LAST;
  assign frame_done = w_wrap && r_slot == 2'd3;
  assign load_ready = !r_pend_full;
  assign w_accept   = load_valid && !r_pend_full;
  assign w_sup      = r_blink[r_slot] && r_phase;
  assign anodo      = (r_state == SHOW && !w_sup) ? ~(4'b0001 << r_slot) : 4'b1111;
  assign code       = r_disp[r_slot];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt   <= '0;
      r_slot  <= '0;
      r_state <= BLANK;
    end else begin
      r_cnt   <= w_wrap ? '0 : r_cnt + CW'(1);
      r_slot  <= w_wrap ? r_slot + 2'd1 : r_slot;
      r_state <= w_wrap ? BLANK : (r_cnt == C_SHOW ? SHOW : r_state);
    end

  // An offer landing on a frame boundary with pending empty only fills pending; it commits one frame later.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_disp       <= {4{BLANK_CODE}};
      r_blink      <= '0;
      r_pend_data  <= '0;
      r_pend_blink <= '0;
      r_pend_full  <= 1'b0;
      r_frame_cnt  <= '0;
      r_phase      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pend_data  <= load_data;
        r_pend_blink <= load_blink;
      end
      if (frame_done && r_pend_full) begin
        r_disp  <= r_pend_data;
        r_blink <= r_pend_blink;
      end
      r_pend_full <= w_accept || (r_pend_full && !frame_done);
      if (frame_done) begin
        r_frame_cnt <= r_frame_cnt == F_LAST ? '0 : r_frame_cnt + FW'(1);
        r_phase     <= r_phase ^ (r_frame_cnt == F_LAST);
      end
    end
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed scoreboard bench; expectations are queued per cycle
// (cycle 0 = reset release) and checked mid-cycle when that cycle is reached.
module tb_display_scheduler;
  logic        clk, rst_n, load_valid, load_ready, frame_done;
  logic [19:0] load_data;
  logic [3:0]  load_blink, anodo;
  logic [4:0]  code;

  typedef struct {int cyc; string tag; int sel; logic [4:0] val;} exp_t;
  exp_t sb[$];
  int cyc, n_chk, n_fail;

  display_scheduler #(.REFRESH_DIV(8), .BLANK_CYC(2), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_blink(load_blink), .load_ready(load_ready), .anodo(anodo), .code(code),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sel: 0 anodo, 1 code, 2 load_ready, 3 frame_done
  task automatic put(input int c, input string tag, input int sel, input logic [4:0] val);
    sb.push_back('{c, tag, sel, val});
  endtask

  task automatic check_cycle();
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].cyc == cyc) begin
        logic [4:0] obs;
        obs = sb[i].sel == 0 ? {1'b0, anodo} : sb[i].sel == 1 ? code :
              sb[i].sel == 2 ? {4'b0, load_ready} : {4'b0, frame_done};
        n_chk++;
        assert (obs === sb[i].val) else begin
          n_fail++;
          $error("FAIL %s cyc=%0d observed=%b expected=%b", sb[i].tag, cyc, obs, sb[i].val);
        end
        sb.delete(i);
      end
  endtask

  task automatic tick();
    #1 check_cycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_blink = '0;
    cyc = -2; n_chk = 0; n_fail = 0;
    put(-1, "rst_an", 0, 5'h0f); put(-1, "rst_code", 1, 5'h10);
    put(-1, "rst_rdy", 2, 5'h01); put(-1, "rst_fd", 3, 5'h00);
    run_to(0);
    rst_n = 1'b1;
    put(0, "c0_an", 0, 5'h0f);   put(1, "c1_an", 0, 5'h0f);
    put(2, "c2_an", 0, 5'h0e);   put(2, "c2_code", 1, 5'h10);
    put(7, "c7_an", 0, 5'h0e);   put(8, "slot1_blank", 0, 5'h0f);
    put(10, "slot1_an", 0, 5'h0d); put(26, "slot3_an", 0, 5'h07);
    put(26, "slot3_code", 1, 5'h10);
    put(30, "fd30", 3, 5'h00);   put(31, "fd31", 3, 5'h01);
    put(32, "fd32", 3, 5'h00);   put(63, "fd63", 3, 5'h01);
    run_to(5);
    load_valid = 1'b1; load_data = {5'd3, 5'd2, 5'd1, 5'd0}; load_blink = 4'b0000;
    put(5, "rdy_pre1", 2, 5'h01); put(6, "rdy_acc1", 2, 5'h00);
    put(31, "rdy_31", 2, 5'h00);  put(31, "code_31_old", 1, 5'h10);
    put(32, "rdy_commit1", 2, 5'h01); put(33, "blank_33", 0, 5'h0f);
    put(34, "d0_an", 0, 5'h0e);   put(34, "d0_code", 1, 5'h00);
    put(39, "d0_code39", 1, 5'h00);
    put(42, "d1_an", 0, 5'h0d);   put(42, "d1_code", 1, 5'h01);
    tick();
    load_valid = 1'b0;
    run_to(10);
    load_valid = 1'b1; load_data = {5'd7, 5'd6, 5'd5, 5'd4}; load_blink = 4'b0001;
    put(20, "rdy_held", 2, 5'h00); put(33, "rdy_acc2", 2, 5'h00);
    put(62, "d3_an", 0, 5'h07);   put(62, "d3_code_old", 1, 5'h03);
    put(64, "rdy_commit2", 2, 5'h01);
    put(66, "blink_on_an", 0, 5'h0f); put(66, "blink_on_code", 1, 5'h04);
    put(71, "blink_on_71", 0, 5'h0f);
    put(74, "d1_unaff_an", 0, 5'h0d); put(74, "d1_unaff_code", 1, 5'h05);
    put(98, "blink_on_f3", 0, 5'h0f); put(106, "d1_f3_an", 0, 5'h0d);
    put(130, "blink_off_an", 0, 5'h0e); put(130, "blink_off_code", 1, 5'h04);
    run_to(33);
    load_valid = 1'b0;
    run_to(127);
    load_valid = 1'b1; load_data = {5'd11, 5'd10, 5'd9, 5'd8}; load_blink = 4'b0000;
    put(127, "fd127", 3, 5'h01); put(127, "rdy127", 2, 5'h01);
    put(128, "rdy_acc3", 2, 5'h00); put(159, "fd159", 3, 5'h01);
    put(160, "rdy_commit3", 2, 5'h01);
    put(162, "d0_new_an", 0, 5'h0e); put(162, "d0_new_code", 1, 5'h08);
    put(170, "d1_new_an", 0, 5'h0d); put(170, "d1_new_code", 1, 5'h09);
    put(179, "d2_an", 0, 5'h0b);  put(179, "d2_code", 1, 5'h0a);
    tick();
    load_valid = 1'b0;
    run_to(163);
    load_valid = 1'b1; load_data = {5'd15, 5'd14, 5'd13, 5'd12}; load_blink = 4'b1111;
    put(163, "rdy_pre4", 2, 5'h01); put(164, "rdy_acc4", 2, 5'h00);
    tick();
    load_valid = 1'b0;
    run_to(180);
    rst_n = 1'b0;
    put(180, "mid_rst_an", 0, 5'h0f); put(180, "mid_rst_code", 1, 5'h10);
    put(180, "mid_rst_rdy", 2, 5'h01); put(180, "mid_rst_fd", 3, 5'h00);
    tick(); tick();
    rst_n = 1'b1;
    put(182, "rel_an", 0, 5'h0f);   put(182, "rel_rdy", 2, 5'h01);
    put(184, "rel_show_an", 0, 5'h0e); put(184, "rel_show_code", 1, 5'h10);
    put(212, "rel_fd_pre", 3, 5'h00); put(213, "rel_fd", 3, 5'h01);
    put(214, "rel_rdy_f1", 2, 5'h01);
    put(216, "no_stale_an", 0, 5'h0e); put(216, "no_stale_code", 1, 5'h10);
    put(224, "no_stale_d1", 1, 5'h10); put(225, "rel_d1_an", 0, 5'h0d);
    run_to(230);
    foreach (sb[i]) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s cyc=%0d never reached, expected=%b", sb[i].tag, sb[i].cyc, sb[i].val);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 27000: clock cycles per digit slot.
REQ-002 SHALL have parameter BLANK_CYC, default 270: blanking cycles at the start of each slot, 1 <= BLANK_CYC < REFRESH_DIV.
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, >= 1: frames per blink half-period.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port load_valid, input, 1: new display frame offered.
REQ-007 SHALL have port load_data, input, 20: four 5-bit hex codes; digit k at [5k+4:5k].
REQ-008 SHALL have port load_blink, input, 4: per-digit blink enable, sampled together with load_data.
REQ-009 SHALL have port load_ready, output, 1: pending buffer empty, offer can be accepted.
REQ-010 SHALL have port anodo, output, 4: active-low digit enables; bit k drives digit k.
REQ-011 SHALL have port code, output, 5: hex code for the external 7-segment decoder; 5'b10000 is the blank/special code.
REQ-012 SHALL have port frame_done, output, 1: single-cycle frame-boundary strobe.

Function
REQ-013 SHALL keep slot counter cnt (0..REFRESH_DIV-1, width clog2(REFRESH_DIV)) and slot index slot (0..3); cnt wraps to 0 and slot increments mod 4 when cnt == REFRESH_DIV-1.
REQ-014 SHALL implement FSM {BLANK, SHOW}: BLANK while cnt < BLANK_CYC, SHOW otherwise; BLANK->SHOW when cnt reaches BLANK_CYC, SHOW->BLANK on cnt wrap.
REQ-015 SHALL drive anodo = 4'b1111 in BLANK; in SHOW, anodo = all ones except bit slot = 0, unless the slot is blink-suppressed.
REQ-016 SHALL drive code = disp_reg[slot] in both states; anodo and code are combinational functions of registered state only.
REQ-017 SHALL blink-suppress a slot (anodo = 4'b1111 for the full slot) when blink_reg[slot] = 1 and blink_phase = 1.
REQ-018 SHALL assert frame_done exactly in the cycle where slot == 3 and cnt == REFRESH_DIV-1 (frame = 4*REFRESH_DIV cycles).
REQ-019 SHALL accept an offer on the rising edge where load_valid && load_ready: capture load_data/load_blink into the pending buffer and deassert load_ready from the next cycle.
REQ-020 SHALL ignore load_data/load_blink when load_ready = 0; offers are not lost if the source holds load_valid.
REQ-021 SHALL, on the edge ending a frame_done cycle with the pending buffer full, copy pending into disp_reg/blink_reg and clear pending (load_ready = 1 the next cycle); new content shows from slot 0 of the next frame, with no tearing.
REQ-022 SHALL, when an accept and a frame boundary coincide with the pending buffer empty, store the new data in pending only and commit it at the following frame boundary.
REQ-023 SHALL count frames in frame_cnt (0..BLINK_FRAMES-1) on frame_done; on wrap, toggle blink_phase.
REQ-024 SHALL let a change of blink_reg at a commit take effect from slot 0 of the next frame without resetting blink_phase.

Reset
REQ-025 SHALL, while rst_n = 0, asynchronously force: cnt = 0, slot = 0, state BLANK, disp_reg = 4 x 5'b10000, blink_reg = 0, pending empty, frame_cnt = 0, blink_phase = 0.
REQ-026 SHALL produce these outputs during and immediately after reset: anodo = 4'b1111, code = 5'b10000, load_ready = 1, frame_done = 0.
REQ-027 SHALL discard any pending or in-progress frame when reset is asserted mid-operation; rst_n release counts as cycle 0 of slot 0 BLANK.

Verification (REFRESH_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2)
REQ-028 Reset release -> cycles 0-1 anodo=1111; cycles 2-7 anodo=1110, code=10000; frame_done high at cycle 31 only, then every 32 cycles.
REQ-029 Offer codes {3,2,1,0} (digit0=0) at cycle 5 -> load_ready=0 from cycle 6; display unchanged until cycle 31; cycles 34-39 anodo=1110, code=0; cycles 42-47 anodo=1101, code=1; load_ready=1 at cycle 32.
REQ-030 Second offer held valid from cycle 10 while pending full -> not accepted until load_ready=1 at cycle 32; accepted at cycle 32, committed at cycle 63.
REQ-031 Offer at cycle 31 (pending empty, frame_done) -> not committed at cycle 31; committed at cycle 63.
REQ-032 load_blink=0001 committed -> digit 0 anodo stays 1111 through slot 0 in frames where blink_phase=1 (2 frames on, 2 off); other digits unaffected.
REQ-033 rst_n low during slot 2 SHOW with pending full -> same cycle anodo=1111, code=10000, load_ready=1; after release, blank codes displayed and no stale commit.
